// File: rtl/cfg_space_arbiter.sv
// Round-robin arbiter sharing one configuration-space port among NUM_REQ requesters.
// Grant pulse, field capture, timed-out wait for ack, then a one-cycle response pulse.
module cfg_space_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       S_CLK,
  input  logic                       PRESETn,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         req_write_i,
  input  logic [NUM_REQ*ADDR_WD-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WD-1:0] req_data_i,
  input  logic [NUM_REQ*4-1:0]       req_strb_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       cs_valid_o,
  output logic                       cs_write_o,
  output logic [ADDR_WD-1:0]         cs_addr_o,
  output logic [DATA_WD-1:0]         cs_data_o,
  output logic [3:0]                 cs_strb_o,
  input  logic                       cs_ack_i,
  input  logic                       cs_rvalid_i,
  input  logic [DATA_WD-1:0]         cs_rdata_i,
  output logic [NUM_REQ-1:0]         rsp_ack_o,
  output logic                       rsp_valid_o,
  output logic [DATA_WD-1:0]         rsp_data_o,
  output logic                       rsp_err_o
);

  localparam int IDX_WD = $clog2(NUM_REQ);
  localparam int CNT_WD = $clog2(TIMEOUT + 1);
  localparam logic [IDX_WD:0]   NREQ_W  = (IDX_WD+1)'(NUM_REQ);
  localparam logic [CNT_WD-1:0] TO_LAST = CNT_WD'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RESPOND = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_WD-1:0]  winner_q, winner_d;
  logic [IDX_WD-1:0]  last_q, last_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [DATA_WD-1:0] data_q, data_d;
  logic [3:0]         strb_q, strb_d;
  logic               rvalid_q, rvalid_d;
  logic [DATA_WD-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [IDX_WD-1:0]  sel_idx;
  logic [IDX_WD:0]    cand;

  // Walk from farthest to nearest so the requester closest after last_q wins.
  always_comb begin
    sel_idx = last_q;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = {1'b0, last_q} + (IDX_WD+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req_i[cand[IDX_WD-1:0]]) sel_idx = cand[IDX_WD-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          winner_d = sel_idx;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        write_d = req_write_i[winner_q];
        addr_d  = req_addr_i[winner_q*ADDR_WD +: ADDR_WD];
        data_d  = req_data_i[winner_q*DATA_WD +: DATA_WD];
        strb_d  = req_strb_i[winner_q*4 +: 4];
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cs_ack_i) begin
          rvalid_d = cs_rvalid_i & ~write_q;
          // Writes leave the broadcast read data untouched.
          if (!write_q) rdata_d = cs_rdata_i;
          err_d    = 1'b0;
          state_d  = ST_RESPOND;
        end else if (cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          rvalid_d = 1'b0;
          state_d  = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_WD'(1);
        end
      end
      ST_RESPOND: begin
        last_d  = winner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_CLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      last_q   <= IDX_WD'(NUM_REQ - 1);
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant_o[gi]   = (state_q == ST_GRANT)   && (winner_q == IDX_WD'(gi));
    assign rsp_ack_o[gi] = (state_q == ST_RESPOND) && (winner_q == IDX_WD'(gi));
  end

  assign cs_valid_o  = (state_q == ST_WAIT);
  assign cs_write_o  = write_q;
  assign cs_addr_o   = addr_q;
  assign cs_data_o   = data_q;
  assign cs_strb_o   = strb_q;
  assign rsp_valid_o = (state_q == ST_RESPOND) && rvalid_q;
  assign rsp_err_o   = (state_q == ST_RESPOND) && err_q;
  assign rsp_data_o  = rdata_q;

endmodule

// File: tb/tb_cfg_space_arbiter.sv
// Directed bench for cfg_space_arbiter (NUM_REQ=4, TIMEOUT=8) with assertion-based checks.
module tb_cfg_space_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic              S_CLK = 1'b0;
  logic              PRESETn;
  logic [NR-1:0]     req_i;
  logic [NR-1:0]     req_write_i;
  logic [NR*AW-1:0]  req_addr_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR*4-1:0]   req_strb_i;
  logic [NR-1:0]     grant_o;
  logic              cs_valid_o;
  logic              cs_write_o;
  logic [AW-1:0]     cs_addr_o;
  logic [DW-1:0]     cs_data_o;
  logic [3:0]        cs_strb_o;
  logic              cs_ack_i;
  logic              cs_rvalid_i;
  logic [DW-1:0]     cs_rdata_i;
  logic [NR-1:0]     rsp_ack_o;
  logic              rsp_valid_o;
  logic [DW-1:0]     rsp_data_o;
  logic              rsp_err_o;

  int errors = 0;
  int checks = 0;

  cfg_space_arbiter #(.NUM_REQ(NR), .DATA_WD(DW), .ADDR_WD(AW), .TIMEOUT(TO)) dut (
    .S_CLK(S_CLK), .PRESETn(PRESETn),
    .req_i(req_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_strb_i(req_strb_i), .grant_o(grant_o),
    .cs_valid_o(cs_valid_o), .cs_write_o(cs_write_o), .cs_addr_o(cs_addr_o),
    .cs_data_o(cs_data_o), .cs_strb_o(cs_strb_o), .cs_ack_i(cs_ack_i),
    .cs_rvalid_i(cs_rvalid_i), .cs_rdata_i(cs_rdata_i), .rsp_ack_o(rsp_ack_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  always #5 S_CLK = ~S_CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int found;
    PRESETn     = 1'b0;
    req_i       = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_strb_i  = '0;
    cs_ack_i    = 1'b0;
    cs_rvalid_i = 1'b0;
    cs_rdata_i  = '0;
    step();
    step();
    check("rst_grant", 64'(grant_o), 64'h0);
    check("rst_cs_valid", 64'(cs_valid_o), 64'h0);
    check("rst_cs_write", 64'(cs_write_o), 64'h0);
    check("rst_cs_addr", 64'(cs_addr_o), 64'h0);
    check("rst_rsp_ack", 64'(rsp_ack_o), 64'h0);
    check("rst_rsp_flags", 64'({rsp_valid_o, rsp_err_o}), 64'h0);
    check("rst_rsp_data", 64'(rsp_data_o), 64'h0);
    PRESETn = 1'b1;
    step();

    // Write from requester 2, ack two cycles after cs_valid rises.
    req_i = 4'b0100;
    req_write_i = 4'b0100;
    req_addr_i[2*AW +: AW] = 16'h0040;
    req_data_i[2*DW +: DW] = 32'hDEADBEEF;
    req_strb_i[2*4 +: 4] = 4'hF;
    step();
    check("wr_grant", 64'(grant_o), 64'h4);
    req_i = '0;
    step();
    check("wr_grant_gone", 64'(grant_o), 64'h0);
    step();
    check("wr_cs_valid", 64'(cs_valid_o), 64'h1);
    check("wr_cs_addr", 64'(cs_addr_o), 64'h0040);
    check("wr_cs_data", 64'(cs_data_o), 64'hDEADBEEF);
    check("wr_cs_write", 64'(cs_write_o), 64'h1);
    check("wr_cs_strb", 64'(cs_strb_o), 64'hF);
    step();
    step();
    check("wr_cs_valid_w2", 64'(cs_valid_o), 64'h1);
    cs_ack_i = 1'b1;
    step();
    cs_ack_i = 1'b0;
    check("wr_rsp_ack", 64'(rsp_ack_o), 64'h4);
    check("wr_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("wr_rsp_err", 64'(rsp_err_o), 64'h0);
    check("wr_rsp_data_kept", 64'(rsp_data_o), 64'h0);
    check("wr_cs_valid_off", 64'(cs_valid_o), 64'h0);
    step();
    check("wr_rsp_ack_gone", 64'(rsp_ack_o), 64'h0);

    // Read from requester 0, ack on the first WAIT_RSP cycle.
    req_i = 4'b0001;
    req_write_i = 4'b0000;
    req_addr_i[0 +: AW] = 16'h0010;
    step();
    check("rd_grant", 64'(grant_o), 64'h1);
    req_i = '0;
    step();
    step();
    check("rd_cs_valid", 64'(cs_valid_o), 64'h1);
    check("rd_cs_write", 64'(cs_write_o), 64'h0);
    check("rd_cs_addr", 64'(cs_addr_o), 64'h0010);
    cs_ack_i = 1'b1;
    cs_rvalid_i = 1'b1;
    cs_rdata_i = 32'h12345678;
    step();
    cs_ack_i = 1'b0;
    cs_rvalid_i = 1'b0;
    check("rd_rsp_ack", 64'(rsp_ack_o), 64'h1);
    check("rd_rsp_valid", 64'(rsp_valid_o), 64'h1);
    check("rd_rsp_data", 64'(rsp_data_o), 64'h12345678);
    step();

    // Continuous requests after reset: grant order 0,1,2,3,0.
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    req_i = 4'b1111;
    cs_ack_i = 1'b1;
    for (int t = 0; t < 5; t++) begin
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
        step();
        if (grant_o != '0) found = 1;
      end
      check($sformatf("rr_grant_%0d", t), 64'(grant_o), 64'(4'b0001 << (t % 4)));
    end
    req_i = '0;
    step();
    step();
    step();
    step();
    cs_ack_i = 1'b0;

    // Read from requester 1 with no ack: timeout after exactly TO cycles.
    req_i = 4'b0010;
    step();
    check("to_grant", 64'(grant_o), 64'h2);
    req_i = '0;
    step();
    step();
    n = 0;
    while (cs_valid_o && n < 20) begin
      n++;
      step();
    end
    check("to_valid_cycles", 64'(n), 64'(TO));
    check("to_rsp_ack", 64'(rsp_ack_o), 64'h2);
    check("to_rsp_err", 64'(rsp_err_o), 64'h1);
    check("to_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("to_rsp_data_kept", 64'(rsp_data_o), 64'h12345678);
    step();
    check("to_idle_ack", 64'({rsp_ack_o, rsp_err_o}), 64'h0);

    // Requester 3 read, ack on the TO-th WAIT_RSP cycle: ack wins.
    req_i = 4'b1000;
    req_addr_i[3*AW +: AW] = 16'h0080;
    step();
    check("late_grant", 64'(grant_o), 64'h8);
    req_i = '0;
    step();
    step();
    for (int c = 1; c < TO; c++) step();
    check("late_cs_valid_last", 64'(cs_valid_o), 64'h1);
    cs_ack_i = 1'b1;
    cs_rvalid_i = 1'b1;
    cs_rdata_i = 32'hCAFEF00D;
    step();
    cs_ack_i = 1'b0;
    cs_rvalid_i = 1'b0;
    check("late_rsp_ack", 64'(rsp_ack_o), 64'h8);
    check("late_rsp_err", 64'(rsp_err_o), 64'h0);
    check("late_rsp_valid", 64'(rsp_valid_o), 64'h1);
    check("late_rsp_data", 64'(rsp_data_o), 64'hCAFEF00D);
    step();

    // Reset during WAIT_RSP aborts silently; restart from requester 0 priority.
    req_i = 4'b0001;
    step();
    check("rst_mid_grant", 64'(grant_o), 64'h1);
    req_i = '0;
    step();
    step();
    check("rst_mid_valid_before", 64'(cs_valid_o), 64'h1);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_valid_async", 64'(cs_valid_o), 64'h0);
    check("rst_mid_no_ack", 64'(rsp_ack_o), 64'h0);
    step();
    check("rst_mid_no_ack_held", 64'(rsp_ack_o), 64'h0);
    PRESETn = 1'b1;
    req_i = 4'b1000;
    step();
    check("post_rst_grant", 64'(grant_o), 64'h8);
    req_i = '0;
    step();
    step();
    cs_ack_i = 1'b1;
    step();
    cs_ack_i = 1'b0;
    check("post_rst_rsp_ack", 64'(rsp_ack_o), 64'h8);
    step();
    req_i = 4'b1111;
    step();
    check("post_rst_next_grant", 64'(grant_o), 64'h1);
    req_i = '0;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
